// File: rtl/mioc_pkg.sv
// Shared encodings for the mioc shift register: operating modes and FSM states.
package mioc_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_LOAD = 2'b01,
      MODE_SHR  = 2'b10,
      MODE_SHL  = 2'b11
   } mode_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

endpackage

// File: rtl/mioc_bit_cnt.sv
// Bit counter for serial shift-out: synchronous clear, increment and terminal-count flag.
module mioc_bit_cnt #(
   parameter int unsigned WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_tc
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Flags the count at which the next shift is the WIDTH-th one.
   assign o_tc = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/mioc_shift_reg.sv
// Universal shift register with hold/load/shift modes and an automatic
// WIDTH-bit serial shift-out sequence with busy/done handshake.
module mioc_shift_reg
   import mioc_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             set,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             ser_in,
   input  logic             start,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             ser_out,
   output logic             busy,
   output logic             done
);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             w_cnt_clr;
   logic             w_cnt_inc;
   logic             w_tc;

   mioc_bit_cnt #(
      .WIDTH (WIDTH)
   ) u_bit_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_cnt_clr),
      .i_inc (w_cnt_inc),
      .o_tc  (w_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_q     <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_q     <= w_q_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      w_done_nxt  = 1'b0;
      w_cnt_clr   = 1'b0;
      w_cnt_inc   = 1'b0;
      if (clr) begin
         w_q_nxt     = '0;
         w_state_nxt = ST_IDLE;
         w_cnt_clr   = 1'b1;
      end else if (set) begin
         w_q_nxt     = '1;
         w_state_nxt = ST_IDLE;
         w_cnt_clr   = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  w_state_nxt = ST_SHIFT;
                  w_cnt_clr   = 1'b1;
               end else begin
                  case (mode_e'(mode))
                     MODE_HOLD: w_q_nxt = r_q;
                     MODE_LOAD: w_q_nxt = d;
                     MODE_SHR:  w_q_nxt = {ser_in, r_q[WIDTH-1:1]};
                     MODE_SHL:  w_q_nxt = {r_q[WIDTH-2:0], ser_in};
                     default:   w_q_nxt = r_q;
                  endcase
               end
            end
            ST_SHIFT: begin
               w_q_nxt   = {ser_in, r_q[WIDTH-1:1]};
               w_cnt_inc = 1'b1;
               // Final shift: counter is parked at zero so IDLE always sees cnt=0.
               if (w_tc) begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b1;
                  w_cnt_clr   = 1'b1;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign q       = r_q;
   assign qbar    = ~r_q;
   assign ser_out = r_q[0];
   assign busy    = (r_state == ST_SHIFT);
   assign done    = r_done;

endmodule
